// File: rtl/ksa_pkg.sv
// Shared types and constants for the RC4 key-scheduling (KSA) blocks.
package ksa_pkg;

    // S memory geometry: 256 bytes, so i, j and data are all 8 bits.
    localparam int S_DEPTH = 256;
    localparam int S_WIDTH = 8;

    // Default number of secret key bytes.
    localparam int DEFAULT_KEY_BYTES = 3;

    // Swap-pass sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        RD_I,
        CAP_I,
        RD_J,
        CAP_J,
        WR_I,
        WR_J,
        DONE
    } state_type;

    // Width of the wrapping key-byte index; at least one bit even for a 1-byte key.
    function automatic int key_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A pass is in progress in every state except the two resting states.
    function automatic logic is_busy_state(input state_type s);
        return !((s == IDLE) || (s == DONE));
    endfunction

endpackage

// File: rtl/rc4_key_sel.sv
// Combinational selection of key byte k from the packed secret key.
// Key byte 0 is the most-significant byte of secret_key.
module rc4_key_sel
    import ksa_pkg::*;
#(
    parameter int KEY_BYTES = DEFAULT_KEY_BYTES
) (
    input  logic [8*KEY_BYTES-1:0]              secret_key,
    input  logic [key_idx_width(KEY_BYTES)-1:0] k,
    output logic [S_WIDTH-1:0]                  key_byte
);

    // Unpack the key into a byte table, byte 0 taken from the top of the vector.
    logic [S_WIDTH-1:0] byte_tbl [KEY_BYTES];

    genvar gi;
    generate
        for (gi = 0; gi < KEY_BYTES; gi++) begin : g_byte
            assign byte_tbl[gi] = secret_key[8*(KEY_BYTES-1-gi) +: 8];
        end
    endgenerate

    // Select byte k; an out-of-range index (unreachable in normal use) yields zero.
    always_comb begin
        key_byte = '0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (int'(k) == b) begin
                key_byte = byte_tbl[b];
            end
        end
    end

endmodule

// File: rtl/ksa_swap_ctrl.sv
// RC4 key-scheduling swap pass over the 256x8 S memory.
// For i = 0..255: j = j + S[i] + key[i mod KEY_BYTES]; swap S[i], S[j].
// Each iteration takes six cycles: read i, capture, read j, capture,
// write S[i] <= S[j], write S[j] <= S[i]. Outputs decode from state and
// registers only, so no input reaches an output combinationally.
module ksa_swap_ctrl
    import ksa_pkg::*;
#(
    parameter int KEY_BYTES = DEFAULT_KEY_BYTES,
    parameter int MEM_DEPTH = S_DEPTH
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    output logic [S_WIDTH-1:0]     mem_addr,
    output logic [S_WIDTH-1:0]     mem_data,
    output logic                   mem_wren,
    input  logic [S_WIDTH-1:0]     mem_q,
    output logic                   busy,
    output logic                   done
);

    localparam int                  KW     = key_idx_width(KEY_BYTES);
    localparam logic [S_WIDTH-1:0]  I_LAST = S_WIDTH'(MEM_DEPTH - 1);
    localparam logic [KW-1:0]       K_LAST = KW'(KEY_BYTES - 1);

    state_type          state_reg, state_next;
    logic [S_WIDTH-1:0] i_reg,  i_next;
    logic [S_WIDTH-1:0] j_reg,  j_next;
    logic [KW-1:0]      k_reg,  k_next;
    logic [S_WIDTH-1:0] si_reg, si_next;
    logic [S_WIDTH-1:0] sj_reg, sj_next;

    logic [S_WIDTH-1:0] key_byte;

    rc4_key_sel #(
        .KEY_BYTES (KEY_BYTES)
    ) u_key_sel (
        .secret_key (secret_key),
        .k          (k_reg),
        .key_byte   (key_byte)
    );

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg <= IDLE;
            i_reg     <= '0;
            j_reg     <= '0;
            k_reg     <= '0;
            si_reg    <= '0;
            sj_reg    <= '0;
        end else begin
            state_reg <= state_next;
            i_reg     <= i_next;
            j_reg     <= j_next;
            k_reg     <= k_next;
            si_reg    <= si_next;
            sj_reg    <= sj_next;
        end
    end

    // Next-state and datapath update; everything holds unless a state changes it.
    always_comb begin
        state_next = state_reg;
        i_next     = i_reg;
        j_next     = j_reg;
        k_next     = k_reg;
        si_next    = si_reg;
        sj_next    = sj_reg;

        case (state_reg)
            IDLE, DONE: begin
                // start only matters while resting; a new pass restarts i, j and k.
                if (start) begin
                    i_next     = '0;
                    j_next     = '0;
                    k_next     = '0;
                    state_next = RD_I;
                end
            end
            RD_I: begin
                state_next = CAP_I;
            end
            CAP_I: begin
                // 8-bit sum wraps mod 256 by construction.
                si_next    = mem_q;
                j_next     = j_reg + mem_q + key_byte;
                state_next = RD_J;
            end
            RD_J: begin
                state_next = CAP_J;
            end
            CAP_J: begin
                sj_next    = mem_q;
                state_next = WR_I;
            end
            WR_I: begin
                state_next = WR_J;
            end
            WR_J: begin
                // Test for the last index before incrementing so i never wraps into a 257th iteration.
                if (i_reg == I_LAST) begin
                    state_next = DONE;
                end else begin
                    i_next     = i_reg + 1'b1;
                    k_next     = (k_reg == K_LAST) ? '0 : k_reg + 1'b1;
                    state_next = RD_I;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Moore output decode from the current state and captured registers.
    always_comb begin
        mem_addr = '0;
        mem_data = '0;
        mem_wren = 1'b0;
        busy     = is_busy_state(state_reg);
        done     = (state_reg == DONE);

        case (state_reg)
            RD_I: begin
                mem_addr = i_reg;
            end
            RD_J: begin
                mem_addr = j_reg;
            end
            WR_I: begin
                mem_addr = i_reg;
                mem_data = sj_reg;
                mem_wren = 1'b1;
            end
            WR_J: begin
                // When i == j this rewrites the same word with si, which is the correct no-op swap.
                mem_addr = j_reg;
                mem_data = si_reg;
                mem_wren = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ksa_swap_ctrl.sv
// Bench for ksa_swap_ctrl: a 256x8 memory with registered read, a software
// RC4 KSA model that queues expected writes, and a monitor that pops and
// compares on every mem_wren cycle.
module tb_ksa_swap_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] secret_key;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_data;
    logic        mem_wren;
    logic [7:0]  mem_q;
    logic        busy;
    logic        done;

    logic [7:0]  mem [256];
    logic [7:0]  model_s [256];
    logic        fill_req = 1'b0;

    logic [15:0] exp_q [$];
    int          n_cmp    = 0;
    int          n_bad    = 0;
    int          wr_count = 0;

    always #10 clk = ~clk;

    ksa_swap_ctrl dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .start      (start),
        .secret_key (secret_key),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .mem_q      (mem_q),
        .busy       (busy),
        .done       (done)
    );

    // S memory: write commits at the clock edge, read data valid the following cycle.
    always @(posedge clk) begin
        if (fill_req) begin
            for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
        end else if (mem_wren) begin
            mem[mem_addr] <= mem_data;
        end
        mem_q <= mem[mem_addr];
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: every write cycle is matched against the head of the expected queue.
    always @(negedge clk) begin
        logic [15:0] e;
        if (mem_wren === 1'b1) begin
            wr_count++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%0d, required no write", mem_addr, mem_data);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_data} !== e) begin
                    n_bad++;
                    $display("FAIL write#%0d: got addr=%0d data=%0d, required addr=%0d data=%0d",
                             wr_count, mem_addr, mem_data, e[15:8], e[7:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_identity();
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
        for (int a = 0; a < 256; a++) model_s[a] = 8'(a);
    endtask

    // Software RC4 KSA on model_s; queues writes numbered [skip, limit).
    task automatic model_pass(input logic [23:0] key, input int skip, input int limit);
        logic [7:0] j;
        logic [7:0] kb;
        logic [7:0] t;
        int         n;
        j = 8'd0;
        n = 0;
        for (int i = 0; i < 256; i++) begin
            kb = 8'(key >> (8 * (2 - (i % 3))));
            j  = j + model_s[i] + kb;
            if (n >= skip && n < limit) exp_q.push_back({8'(i), model_s[j]});
            n++;
            if (n >= skip && n < limit) exp_q.push_back({j, model_s[i]});
            n++;
            t          = model_s[i];
            model_s[i] = model_s[j];
            model_s[j] = t;
        end
    endtask

    // Launch a pass and track busy/done timing; optionally pulse start mid-pass.
    task automatic run_pass(input bit pulses);
        int c;
        int busy_cnt;
        int wr0;
        bit seen;
        wr0      = wr_count;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        c        = 1;
        busy_cnt = 0;
        seen     = 1'b0;
        check("busy_cycle1", int'(busy), 1);
        check("done_cycle1", int'(done), 0);
        while (!seen && c < 2000) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cnt++;
                start = pulses && (c == 10 || c == 800);
                tick();
                c++;
            end
        end
        start = 1'b0;
        check("done_first_cycle", c, 1537);
        check("busy_at_done", int'(busy), 0);
        check("busy_cycles", busy_cnt, 1536);
        check("wren_cycles", wr_count - wr0, 512);
        check("queue_drained", exp_q.size(), 0);
        $display("pass key=%06h: done at cycle %0d, %0d writes", secret_key, c, wr_count - wr0);
    endtask

    task automatic check_image(input string name);
        for (int b = 0; b < 256; b++) check(name, int'(mem[b]), int'(model_s[b]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        reset      = 1'b1;
        start      = 1'b0;
        secret_key = 24'h0;
        repeat (3) tick();
        check("rst_wren", int'(mem_wren), 0);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_data", int'(mem_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        reset = 1'b0;
        tick();

        // Key 0x000000 with hand-computed first three iterations; start pulses mid-pass.
        fill_identity();
        secret_key = 24'h000000;
        exp_q.push_back({8'd0, 8'd0});
        exp_q.push_back({8'd0, 8'd0});
        exp_q.push_back({8'd1, 8'd1});
        exp_q.push_back({8'd1, 8'd1});
        exp_q.push_back({8'd2, 8'd3});
        exp_q.push_back({8'd3, 8'd2});
        model_pass(secret_key, 6, 512);
        run_pass(1'b1);
        check_image("image_key000000");

        // Key 0x010203 with hand-computed first two iterations.
        fill_identity();
        secret_key = 24'h010203;
        exp_q.push_back({8'd0, 8'd1});
        exp_q.push_back({8'd1, 8'd0});
        exp_q.push_back({8'd1, 8'd3});
        exp_q.push_back({8'd3, 8'd0});
        model_pass(secret_key, 4, 512);
        run_pass(1'b0);
        check_image("image_key010203");

        // Full pass, key 0x00033C.
        fill_identity();
        secret_key = 24'h00033C;
        model_pass(secret_key, 0, 512);
        run_pass(1'b0);
        check_image("image_key00033C");

        // Restart from DONE without refilling: j must restart at zero.
        secret_key = 24'h0A0B0C;
        model_pass(secret_key, 0, 512);
        run_pass(1'b0);
        check_image("image_restart");

        // Reset during the WR_I of iteration 116 (cycle 701): 233 writes, then nothing.
        fill_identity();
        secret_key = 24'h00033C;
        model_pass(secret_key, 0, 233);
        wr0   = wr_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 701; c++) tick();
        check("wren_before_reset", int'(mem_wren), 1);
        reset = 1'b1;
        tick();
        check("midrst_wren", int'(mem_wren), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_addr", int'(mem_addr), 0);
        reset = 1'b0;
        repeat (20) tick();
        check("midrst_writes", wr_count - wr0, 233);
        check("midrst_queue", exp_q.size(), 0);
        check("midrst_idle_busy", int'(busy), 0);
        $display("reset mid-pass: %0d writes before reset", wr_count - wr0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
